// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: segment fonts, converter FSM states, display limits.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_VALUE  = 9999;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  // Active-low {dp,g,f,e,d,c,b,a}, decimal point off
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_UPDATE = 2'd2
  } conv_state_t;

  function automatic logic [7:0] font_of(input logic [3:0] d);
    logic [7:0] f;
    case (d)
      4'd0:    f = FONT_0;
      4'd1:    f = FONT_1;
      4'd2:    f = FONT_2;
      4'd3:    f = FONT_3;
      4'd4:    f = FONT_4;
      4'd5:    f = FONT_5;
      4'd6:    f = FONT_6;
      4'd7:    f = FONT_7;
      4'd8:    f = FONT_8;
      4'd9:    f = FONT_9;
      default: f = FONT_BLANK;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter; saturates inputs above 9999 and
// spends one shift per input bit, then raises done for a single UPDATE cycle.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);

  conv_state_t       state;
  conv_state_t       state_next;
  logic [BIN_W-1:0]  bin;
  logic [3:0]        cnt;
  logic [BCD_W-1:0]  bcd_adj;

  function automatic logic [BIN_W-1:0] saturate(input logic [DATA_W-1:0] v);
    if (32'(v) > 32'(MAX_VALUE)) return BIN_W'(MAX_VALUE);
    return BIN_W'(v);
  endfunction

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_CONV;
      ST_CONV:   if (cnt == 4'(BIN_W - 1)) state_next = ST_UPDATE;
      ST_UPDATE: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_UPDATE);
  assign bcd_adj = add3(bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      bin <= saturate(value);
      bcd <= '0;
      cnt <= '0;
    end else if (state == ST_CONV) begin
      bcd <= {bcd_adj[BCD_W-2:0], bin[BIN_W-1]};
      bin <= {bin[BIN_W-2:0], 1'b0};
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND driver: handshake value capture, BCD conversion, digit scanning.
// Optional leading-zero blanking is enabled by defining FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int DATA_W  = 14
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_value,
  input  logic [3:0]        i_dp,
  output logic              o_ready,
  output logic [3:0]        o_fnd_com,
  output logic [7:0]        o_fnd_font
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic                  busy;
  logic                  done;
  logic                  ready;
  logic [BCD_W-1:0]      conv_bcd;
  logic [BCD_W-1:0]      disp_bcd;
  logic [NUM_DIGITS-1:0] dp_hold;
  logic [NUM_DIGITS-1:0] disp_dp;
  logic [NUM_DIGITS-1:0] blank;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic [1:0]            pos;
  logic [1:0]            new_pos;
  logic [3:0]            digit;
  logic [7:0]            seg;

  assign ready   = ~busy;
  assign o_ready = ready;

  bin2bcd_seq #(.DATA_W(DATA_W)) u_conv (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .start (i_valid),
    .value (i_value),
    .busy  (busy),
    .done  (done),
    .bcd   (conv_bcd)
  );

  // Display register swaps in one edge so a scan slot never sees a half-updated value
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      dp_hold  <= '0;
      disp_dp  <= '0;
      disp_bcd <= '0;
    end else begin
      if (i_valid && ready) dp_hold <= i_dp;
      if (done) begin
        disp_bcd <= conv_bcd;
        disp_dp  <= dp_hold;
      end
    end
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank    = '0;
    blank[3] = (disp_bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_bcd[7:4] == 4'd0);
  end
`else
  assign blank = '0;
`endif

  assign tick    = (presc == PW'(DIV - 1));
  assign new_pos = pos + 2'd1;
  assign digit   = disp_bcd[{new_pos, 2'b00} +: 4];
  assign seg     = blank[new_pos] ? FONT_BLANK : font_of(digit);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc      <= '0;
      pos        <= '0;
      o_fnd_com  <= 4'b1111;
      o_fnd_font <= FONT_BLANK;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        pos        <= new_pos;
        o_fnd_com  <= ~(4'b0001 << new_pos);
        o_fnd_font <= {~disp_dp[new_pos], seg[6:0]};
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench for fnd_scan_controller at CLK_HZ=1000, SCAN_HZ=100 (one scan tick per 10 clocks).
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [13:0] value = '0;
  logic [3:0]  dp = '0;
  logic        ready;
  logic [3:0]  com;
  logic [7:0]  font;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  int model_val = 0;
  logic [3:0] model_dp = '0;
  logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  always #5 clk = ~clk;

  // Clocks since reset release; the scan tick lands on every edge where cyc is a multiple of 10
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  fnd_scan_controller #(.CLK_HZ(1000), .SCAN_HZ(100), .DATA_W(14)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_valid    (valid),
    .i_value    (value),
    .i_dp       (dp),
    .o_ready    (ready),
    .o_fnd_com  (com),
    .o_fnd_font (font)
  );

  function automatic int pow10(int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [7:0] exp_font(int p);
    logic [7:0] f;
    f = font_tab[(model_val / pow10(p)) % 10];
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (p > 0 && model_val < pow10(p)) f = 8'hFF;
`endif
    f[7] = ~model_dp[p];
    return f;
  endfunction

  function automatic logic [3:0] exp_com(int p);
    logic [3:0] c = 4'b1111;
    c[p] = 1'b0;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_tick(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 25 && !ok; i++) begin
      step();
      if (cyc > 0 && cyc % 10 == 0) ok = 1'b1;
    end
  endtask

  task automatic check_slot(string name);
    bit ok;
    int p;
    next_tick(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: no scan tick within 25 cycles", name);
    end else begin
      p = (cyc / 10) % 4;
      if (com !== exp_com(p) || font !== exp_font(p)) begin
        n_fail++;
        $display("FAIL %s pos%0d: com=%b font=%h, expected com=%b font=%h",
                 name, p, com, font, exp_com(p), exp_font(p));
      end
    end
  endtask

  task automatic wait_ready(string name);
    int n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: o_ready never returned high", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (com !== 4'b1111 || font !== 8'hFF || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: com=%b font=%h ready=%b, expected 1111 ff 1", com, font, ready);
    end
    rst_n = 1'b1;
    model_val = 0;
    model_dp  = '0;
    repeat (9) step();
    n_checks++;
    if (com !== 4'b1111 || font !== 8'hFF) begin
      n_fail++;
      $display("FAIL pre_tick cyc%0d: com=%b font=%h, expected 1111 ff", cyc, com, font);
    end
    step();
    n_checks++;
    if (cyc != 10 || com !== 4'b1101) begin
      n_fail++;
      $display("FAIL first_tick cyc%0d: com=%b, expected 1101 at cycle 10", cyc, com);
    end
    for (int i = 0; i < 4; i++) check_slot("scan_after_reset");
    repeat (5) step();
    n_checks++;
    if (com !== exp_com((cyc / 10) % 4)) begin
      n_fail++;
      $display("FAIL mid_slot_hold: com=%b, expected %b", com, exp_com((cyc / 10) % 4));
    end
  endtask

  // align < 0 picks no phase; align = 4 puts the display update on a tick edge
  task automatic test_convert(string name, int v, logic [3:0] d, int align, bit pulse);
    int guard = 0;
    wait_ready(name);
    if (align >= 0) begin
      while (cyc % 10 != align && guard < 12) begin
        step();
        guard++;
      end
    end
    valid = 1'b1;
    value = 14'(v);
    dp    = d;
    step();
    valid = 1'b0;
    value = 14'($urandom);
    dp    = 4'($urandom);
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) begin
        if (pulse && k == 5) begin
          valid = 1'b1;
          value = 14'd5;
          dp    = 4'hF;
        end
        step();
        valid = 1'b0;
      end
      n_checks++;
      if (ready !== (k == 15)) begin
        n_fail++;
        $display("FAIL %s ready after edge %0d: got %b, expected %b", name, k, ready, (k == 15));
      end
      if (cyc % 10 == 0) begin
        n_checks++;
        if (font !== exp_font((cyc / 10) % 4)) begin
          n_fail++;
          $display("FAIL %s old digits shown during conversion: font=%h, expected %h",
                   name, font, exp_font((cyc / 10) % 4));
        end
      end
    end
    model_val = (v > 9999) ? 9999 : v;
    model_dp  = d;
    for (int i = 0; i < 4; i++) check_slot(name);
  endtask

  task automatic test_reset_during_conv();
    wait_ready("reset_conv");
    valid = 1'b1;
    value = 14'd4321;
    dp    = 4'b1111;
    step();
    valid = 1'b0;
    repeat (5) step();
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (com !== 4'b1111 || font !== 8'hFF || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_during_conv: com=%b font=%h ready=%b, expected 1111 ff 1", com, font, ready);
    end
    repeat (2) step();
    rst_n = 1'b1;
    model_val = 0;
    model_dp  = '0;
    for (int i = 0; i < 4; i++) check_slot("after_conv_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_convert("random", int'($urandom_range(0, 16383)), 4'($urandom),
                   int'($urandom_range(0, 9)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_convert("value_1234", 1234, 4'b0010, -1, 1'b0);
    test_convert("saturate_12000", 12000, 4'b0000, 4, 1'b0);
    test_convert("ignore_busy_valid", 1234, 4'b0010, -1, 1'b1);
    test_convert("value_7", 7, 4'b0000, 4, 1'b0);
    test_convert("value_1000", 1000, 4'b0100, -1, 1'b0);
    test_convert("value_0_dp", 0, 4'b1001, -1, 1'b0);
    test_reset_during_conv();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
